return_stack: RTL and testbench
===============================

# return_stack

Return address stack (RAS) that sits directly downstream of the branch target buffer in the fetch stage. It consumes the BTB's per-fetch-package branch prediction: calls push a return address, and returns pop and supply the predicted target. It exports its top-of-stack pointer and occupancy so the branch unit can checkpoint them. On a mispredict it restores the stack state and re-applies the resolved branch's own effect.

## Interface
Parameters:
- DEPTH, 8, number of stack entries; power of two, at least 2
- PTR_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- IN_valid  in  1  a predicted branch from the BTB was accepted by fetch this cycle
- IN_isCall  in  1  predicted branch is BT_CALL
- IN_isRet  in  1  predicted branch is BT_RETURN
- IN_retAddr  in  31  return address for a call (halfword address, bits [31:1]): branch pc + 2 if compressed, else + 4
- IN_recover  in  1  mispredict recovery request from the branch unit
- IN_recoverTos  in  PTR_W  checkpointed top-of-stack index
- IN_recoverCnt  in  PTR_W+1  checkpointed occupancy
- IN_recoverIsCall  in  1  resolved branch is a call
- IN_recoverIsRet  in  1  resolved branch is a return
- IN_recoverAddr  in  31  return address of the resolved branch, if it is a call
- OUT_retValid  out  1  stack non-empty (count != 0)
- OUT_retAddr  out  31  entry at top of stack; predicted target for a return
- OUT_tos  out  PTR_W  current top-of-stack index, for checkpointing
- OUT_cnt  out  PTR_W+1  current occupancy, for checkpointing

## Operation
- State:
  - stack[DEPTH] of 31 bits
  - tos of PTR_W bits, modulo-DEPTH wraparound
  - cnt in 0..DEPTH, saturating
- Outputs are combinational from state: OUT_retAddr = stack[tos]; OUT_retValid = (cnt != 0); OUT_tos = tos; OUT_cnt = cnt.
- Effective operation per cycle:
  - If IN_recover: base state = (IN_recoverTos, IN_recoverCnt), with call = IN_recoverIsCall, ret = IN_recoverIsRet, addr = IN_recoverAddr.
  - Else if IN_valid: base state = (tos, cnt), with call/ret/addr taken from the IN_ ports.
  - Else: hold.
- Recovery has priority. A simultaneous IN_valid is dropped entirely.
- Applied to base (t, c):
  - push only: stack[t+1] <= addr; tos <= t+1; cnt <= min(c+1, DEPTH).
  - pop only: tos <= t-1; cnt <= (c == 0) ? 0 : c-1. Stack contents are unchanged.
  - call and ret together (coroutine jump): stack[t] <= addr; tos <= t; cnt <= max(c, 1).
  - neither: tos <= t; cnt <= c. This still restores the checkpoint on recovery.
- Overflow: a push at cnt == DEPTH silently overwrites the oldest entry (wraparound); cnt stays DEPTH.
- Underflow: a pop at cnt == 0 still decrements tos; cnt stays 0 and OUT_retValid stays 0.
- Entries overwritten after a checkpoint are not restored; stale return targets after recovery are accepted. Correctness is preserved by branch resolution.
- IN_isCall and IN_isRet are ignored when IN_valid = 0.

## Timing
- Reset (rst high at posedge): tos = 0, cnt = 0, all stack entries = 0. After reset: OUT_retValid = 0, OUT_retAddr = 0, OUT_tos = 0, OUT_cnt = 0.
- rst overrides IN_recover and IN_valid in the same cycle. Reset mid-sequence discards all state.
- Update latency 1 cycle: an operation at edge N is visible on the outputs immediately after edge N.
- A return predicted in cycle N uses OUT_retAddr as it stood before edge N, i.e. the top before the pop.
- Back-to-back operations every cycle are supported. No handshake and no stall: the block always accepts.
- One stack write port: at most one entry is written per cycle.

## Test plan
- Reset, then call with addr 0x100 -> OUT_retValid = 1, OUT_retAddr = 0x100, OUT_tos = 1, OUT_cnt = 1. Then return -> OUT_retValid = 0, OUT_tos = 0.
- DEPTH = 8: nine calls with addrs 1..9, then eight returns -> OUT_retAddr reads 9, 8, …, 2 before each pop. OUT_cnt goes 8 → 0, never exceeding 8.
- Pop on empty stack after reset -> OUT_tos = 7, OUT_cnt = 0, OUT_retValid = 0. A following call with 0x40 -> OUT_tos = 0, OUT_retAddr = 0x40, OUT_cnt = 1.
- Call+ret in the same cycle with addr 0x200 at tos = 3, cnt = 3 -> stack[3] = 0x200, tos = 3, cnt = 3.
- Calls 0xA, 0xB (checkpoint tos = 1, cnt = 1 taken before 0xB), then a wrong-path return. Assert IN_recover with tos 1, cnt 1, IN_recoverIsCall = 1, IN_recoverAddr 0xC, while IN_valid = 1 with a call -> tos = 2, cnt = 2, OUT_retAddr = 0xC; the IN_valid call is ignored.
- rst asserted in the same cycle as IN_recover and IN_valid -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/return_stack.sv
// Return address stack for fetch-stage return prediction, with checkpoint restore on mispredict.
// Calls push, returns pop, and a call+return pair replaces the top entry.
module return_stack #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  input  logic             IN_isCall,
  input  logic             IN_isRet,
  input  logic [30:0]      IN_retAddr,
  input  logic             IN_recover,
  input  logic [PTR_W-1:0] IN_recoverTos,
  input  logic [PTR_W:0]   IN_recoverCnt,
  input  logic             IN_recoverIsCall,
  input  logic             IN_recoverIsRet,
  input  logic [30:0]      IN_recoverAddr,
  output logic             OUT_retValid,
  output logic [30:0]      OUT_retAddr,
  output logic [PTR_W-1:0] OUT_tos,
  output logic [PTR_W:0]   OUT_cnt
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [30:0]      stack_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0] base_tos;
  logic [PTR_W:0]   base_cnt;
  logic             op_call, op_ret;
  logic [30:0]      op_addr;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // Recovery wins over a same-cycle prediction; with neither, the base is the
  // current state and no operation is applied, which is a plain hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    base_tos = tos_q;
    base_cnt = cnt_q;
    op_call  = 1'b0;
    op_ret   = 1'b0;
    op_addr  = '0;
    if (IN_recover) begin
      base_tos = IN_recoverTos;
      base_cnt = IN_recoverCnt;
      op_call  = IN_recoverIsCall;
      op_ret   = IN_recoverIsRet;
      op_addr  = IN_recoverAddr;
    end else if (IN_valid) begin
      op_call  = IN_isCall;
      op_ret   = IN_isRet;
      op_addr  = IN_retAddr;
    end
  end

  always_comb begin
    tos_d  = base_tos;
    cnt_d  = base_cnt;
    wr_en  = 1'b0;
    wr_idx = base_tos;
    unique case ({op_call, op_ret})
      2'b10: begin
        tos_d  = base_tos + PTR_W'(1);
        wr_en  = 1'b1;
        wr_idx = tos_d;
        cnt_d  = (base_cnt >= CNT_MAX) ? CNT_MAX : base_cnt + (PTR_W+1)'(1);
      end
      2'b01: begin
        tos_d = base_tos - PTR_W'(1);
        cnt_d = (base_cnt == '0) ? '0 : base_cnt - (PTR_W+1)'(1);
      end
      2'b11: begin
        wr_en = 1'b1;
        cnt_d = (base_cnt == '0) ? (PTR_W+1)'(1) : base_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      tos_q <= '0;
      cnt_q <= '0;
      // NOTE: the entries are reset so OUT_retAddr reads 0 after reset; this
      // keeps the array in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (wr_en) stack_q[wr_idx] <= op_addr;
    end
  end

  assign OUT_retValid = (cnt_q != '0);
  assign OUT_retAddr  = stack_q[tos_q];
  assign OUT_tos      = tos_q;
  assign OUT_cnt      = cnt_q;

endmodule

// File: tb/tb_return_stack.sv
// Scoreboarded bench for return_stack: directed scenarios followed by random traffic,
// compared against an arithmetic model of the stack kept in the bench.
module tb_return_stack;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             IN_valid, IN_isCall, IN_isRet;
  logic [30:0]      IN_retAddr;
  logic             IN_recover, IN_recoverIsCall, IN_recoverIsRet;
  logic [PTR_W-1:0] IN_recoverTos;
  logic [PTR_W:0]   IN_recoverCnt;
  logic [30:0]      IN_recoverAddr;
  logic             OUT_retValid;
  logic [30:0]      OUT_retAddr;
  logic [PTR_W-1:0] OUT_tos;
  logic [PTR_W:0]   OUT_cnt;

  return_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .IN_valid(IN_valid), .IN_isCall(IN_isCall), .IN_isRet(IN_isRet), .IN_retAddr(IN_retAddr),
    .IN_recover(IN_recover), .IN_recoverTos(IN_recoverTos), .IN_recoverCnt(IN_recoverCnt),
    .IN_recoverIsCall(IN_recoverIsCall), .IN_recoverIsRet(IN_recoverIsRet),
    .IN_recoverAddr(IN_recoverAddr),
    .OUT_retValid(OUT_retValid), .OUT_retAddr(OUT_retAddr), .OUT_tos(OUT_tos), .OUT_cnt(OUT_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [30:0] addr;
    int          tos;
    int          cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a circular buffer with a signed-free index kept in 0..DEPTH-1.
  logic [30:0] m_stack [DEPTH];
  int          m_tos, m_cnt;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;
    m_tos = 0;
    m_cnt = 0;
  endtask

  task automatic model_apply(input int t, input int c, input bit call, input bit ret,
                             input logic [30:0] addr);
    if (call && !ret) begin
      t = (t + 1) % DEPTH;
      m_stack[t] = addr;
      c = (c + 1 > DEPTH) ? DEPTH : c + 1;
    end else if (ret && !call) begin
      t = (t + DEPTH - 1) % DEPTH;
      c = (c == 0) ? 0 : c - 1;
    end else if (call && ret) begin
      m_stack[t] = addr;
      c = (c < 1) ? 1 : c;
    end
    m_tos = t;
    m_cnt = c;
  endtask

  // One cycle of stimulus: drive at negedge, advance the model, queue the expected outputs.
  task automatic step(input string tag, input bit r, input bit v, input bit c, input bit rt,
                      input logic [30:0] a, input bit rec, input int rtos, input int rcnt,
                      input bit rc, input bit rr, input logic [30:0] ra);
    exp_t e;
    @(negedge clk);
    rst = r; IN_valid = v; IN_isCall = c; IN_isRet = rt; IN_retAddr = a;
    IN_recover = rec; IN_recoverTos = PTR_W'(rtos); IN_recoverCnt = (PTR_W+1)'(rcnt);
    IN_recoverIsCall = rc; IN_recoverIsRet = rr; IN_recoverAddr = ra;
    if (r) model_reset();
    else if (rec) model_apply(rtos, rcnt, rc, rr, ra);
    else if (v) model_apply(m_tos, m_cnt, c, rt, a);
    e.valid = (m_cnt != 0);
    e.addr  = m_stack[m_tos];
    e.tos   = m_tos;
    e.cnt   = m_cnt;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic op(input string tag, input bit c, input bit rt, input logic [30:0] a);
    step(tag, 1'b0, 1'b1, c, rt, a, 1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: outputs settle after each posedge; compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".retValid"}, OUT_retValid, e.valid);
        check({e.tag, ".retAddr"},  OUT_retAddr,  e.addr);
        check({e.tag, ".tos"},      OUT_tos,      e.tos);
        check({e.tag, ".cnt"},      OUT_cnt,      e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; IN_valid = 1'b0; IN_isCall = 1'b0; IN_isRet = 1'b0; IN_retAddr = '0;
    IN_recover = 1'b0; IN_recoverTos = '0; IN_recoverCnt = '0;
    IN_recoverIsCall = 1'b0; IN_recoverIsRet = 1'b0; IN_recoverAddr = '0;
    model_reset();

    do_reset("reset");
    op("call_0x100", 1'b1, 1'b0, 31'h100);
    op("ret_0x100", 1'b0, 1'b1, '0);

    do_reset("reset2");
    for (int i = 1; i <= 9; i++) op("ovf_call", 1'b1, 1'b0, 31'(i));
    for (int i = 0; i < 8; i++) op("ovf_ret", 1'b0, 1'b1, '0);

    do_reset("reset3");
    op("underflow_pop", 1'b0, 1'b1, '0);
    op("call_after_uf", 1'b1, 1'b0, 31'h40);

    do_reset("reset4");
    for (int i = 1; i <= 3; i++) op("fill3", 1'b1, 1'b0, 31'(i));
    op("coroutine", 1'b1, 1'b1, 31'h200);
    op("idle_ignores_flags", 1'b0, 1'b0, '0);
    step("invalid_call", 1'b0, 1'b0, 1'b1, 1'b0, 31'h55, 1'b0, 0, 0, 1'b0, 1'b0, '0);

    do_reset("reset5");
    op("call_A", 1'b1, 1'b0, 31'hA);
    op("call_B", 1'b1, 1'b0, 31'hB);
    op("wrong_ret", 1'b0, 1'b1, '0);
    step("recover_call", 1'b0, 1'b1, 1'b1, 1'b0, 31'h77, 1'b1, 1, 1, 1'b1, 1'b0, 31'hC);

    step("rst_over_recover", 1'b1, 1'b1, 1'b1, 1'b0, 31'h99, 1'b1, 5, 3, 1'b1, 1'b0, 31'h33);

    for (int n = 0; n < 1500; n++) begin
      bit r, v, rec;
      r   = ($urandom_range(99) == 0);
      rec = ($urandom_range(9) == 0);
      v   = ($urandom_range(3) != 0);
      step("random", r, v, 1'($urandom), 1'($urandom), 31'($urandom),
           rec, $urandom_range(DEPTH-1), $urandom_range(DEPTH),
           1'($urandom), 1'($urandom), 31'($urandom));
    end

    @(negedge clk);
    rst = 1'b0; IN_valid = 1'b0; IN_recover = 1'b0;
    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
